k007232_mixer: RTL and testbench

K007232_MIXER -- requirements
Module: k007232_mixer

---
 rtl/k007232_mixer_pkg.sv | 27 ++
 rtl/k007232_mixer_mul.sv | 50 +++++
 rtl/k007232_mixer.sv | 122 ++++++++++++
 tb/tb_k007232_mixer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/k007232_mixer_pkg.sv
// k007232_mixer_pkg: shared types and constants for the K007232 channel mixer.
// Sample coding, multiplier widths and the mixer FSM state encoding.
package k007232_mixer_pkg;

   localparam int SMP_W     = 7;
   localparam int VOL_W     = 4;
   localparam int SUM_W     = 12;
   localparam int SMP_MID   = 64;
   localparam int MUL_STEPS = 4;
   localparam int CNT_W     = $clog2(MUL_STEPS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_SUM
   } state_t;

   // Offset-binary sample to two's complement (64 -> 0).
   function automatic logic signed [SMP_W-1:0] smp_to_s(
      input logic [SMP_W-1:0] s
   );
      logic [SMP_W-1:0] mid;
      mid = SMP_W'(SMP_MID);
      return $signed(s - mid);
   endfunction

endpackage

// File: rtl/k007232_mixer_mul.sv
// k007232_mixer_mul: serial signed x unsigned shift-add multiplier.
// Loads on start, then one gain bit per cycle LSB first; done pulses after the last step.
module k007232_mixer_mul
   import k007232_mixer_pkg::*;
(
   input  logic                    clk,
   input  logic                    res,
   input  logic                    start,
   input  logic signed [SMP_W-1:0] a,
   input  logic        [VOL_W-1:0] b,
   output logic signed [SUM_W-1:0] p,
   output logic                    done
);

   logic signed [SUM_W-1:0] mc;
   logic        [VOL_W-1:0] mp;
   logic        [CNT_W-1:0] cnt;
   logic                    run;

   always_ff @(posedge clk) begin
      if (res) begin
         mc   <= '0;
         mp   <= '0;
         p    <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            mc  <= {{(SUM_W-SMP_W){a[SMP_W-1]}}, a};
            mp  <= b;
            p   <= '0;
            cnt <= '0;
            run <= 1'b1;
         end else if (run) begin
            if (mp[0])
               p <= p + mc;
            mc  <= mc <<< 1;
            mp  <= mp >> 1;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(MUL_STEPS-1)) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/k007232_mixer.sv
// k007232_mixer: two-channel volume-scaled sample mixer with serial multipliers.
// Define K007232_MIXER_SAT_EN to saturate instead of shift when OUT_W < 12.
module k007232_mixer
   import k007232_mixer_pkg::*;
#(
   parameter int OUT_W = 12
) (
   input  logic                    CLK,
   input  logic                    RES,
   input  logic        [SMP_W-1:0] ASD,
   input  logic        [SMP_W-1:0] BSD,
   input  logic                    SMP_STB,
   input  logic                    VOL_WE,
   input  logic        [7:0]       VOL_D,
   input  logic                    DROP_CLR,
   output logic signed [OUT_W-1:0] MIX,
   output logic                    MIX_VLD,
   output logic                    BUSY,
   output logic                    DROP
);

   state_t                  state;
   logic        [VOL_W-1:0] vol_a;
   logic        [VOL_W-1:0] vol_b;
   logic        [CNT_W-1:0] step;
   logic                    start;
   logic signed [SUM_W-1:0] prod_a;
   logic signed [SUM_W-1:0] prod_b;
   logic signed [SUM_W-1:0] sum12;
   logic signed [OUT_W-1:0] mix_nxt;
   logic                    done_a;
   logic                    done_b;

   assign start = (state == ST_IDLE) && SMP_STB;
   assign BUSY  = (state != ST_IDLE);
   assign sum12 = prod_a + prod_b;

   k007232_mixer_mul u_mul_a (
      .clk   (CLK),
      .res   (RES),
      .start (start),
      .a     (smp_to_s(ASD)),
      .b     (vol_a),
      .p     (prod_a),
      .done  (done_a)
   );

   k007232_mixer_mul u_mul_b (
      .clk   (CLK),
      .res   (RES),
      .start (start),
      .a     (smp_to_s(BSD)),
      .b     (vol_b),
      .p     (prod_b),
      .done  (done_b)
   );

`ifdef K007232_MIXER_SAT_EN
   localparam logic signed [SUM_W-1:0] MIX_MAX = SUM_W'((2**(OUT_W-1))-1);
   localparam logic signed [SUM_W-1:0] MIX_MIN = SUM_W'(-(2**(OUT_W-1)));

   always_comb begin
      mix_nxt = OUT_W'(sum12);
      if (sum12 > MIX_MAX)
         mix_nxt = OUT_W'(MIX_MAX);
      else if (sum12 < MIX_MIN)
         mix_nxt = OUT_W'(MIX_MIN);
   end
`else
   always_comb begin
      mix_nxt = OUT_W'(sum12 >>> (SUM_W-OUT_W));
   end
`endif

   always_ff @(posedge CLK) begin
      if (RES) begin
         vol_a <= '0;
         vol_b <= '0;
      end else if (VOL_WE) begin
         vol_a <= VOL_D[3:0];
         vol_b <= VOL_D[7:4];
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         state   <= ST_IDLE;
         step    <= '0;
         MIX     <= '0;
         MIX_VLD <= 1'b0;
         DROP    <= 1'b0;
      end else begin
         MIX_VLD <= 1'b0;
         if (DROP_CLR)
            DROP <= 1'b0;
         // A strobe while busy is discarded; setting DROP wins over a clear.
         if (SMP_STB && state != ST_IDLE)
            DROP <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               step <= '0;
               if (SMP_STB)
                  state <= ST_MUL;
            end
            ST_MUL: begin
               step <= step + 1'b1;
               if (step == CNT_W'(MUL_STEPS-1))
                  state <= ST_SUM;
            end
            ST_SUM: begin
               if (done_a && done_b) begin
                  MIX     <= mix_nxt;
                  MIX_VLD <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_k007232_mixer.sv
// tb_k007232_mixer: vector table, corner sequences and random samples vs a model.
// Runs a 12-bit and a 10-bit instance side by side on shared inputs.
module tb_k007232_mixer;

   logic              clk;
   logic              res;
   logic [6:0]        asd;
   logic [6:0]        bsd;
   logic              smp_stb;
   logic              vol_we;
   logic [7:0]        vol_d;
   logic              drop_clr;
   logic signed [11:0] mix12;
   logic signed [9:0]  mix10;
   logic              vld12, vld10;
   logic              busy12, busy10;
   logic              drop12, drop10;

   int checks = 0;
   int errors = 0;
   int vol_a  = 0;
   int vol_b  = 0;

   k007232_mixer #(.OUT_W(12)) u_dut (
      .CLK(clk), .RES(res), .ASD(asd), .BSD(bsd), .SMP_STB(smp_stb),
      .VOL_WE(vol_we), .VOL_D(vol_d), .DROP_CLR(drop_clr),
      .MIX(mix12), .MIX_VLD(vld12), .BUSY(busy12), .DROP(drop12)
   );

   k007232_mixer #(.OUT_W(10)) u_dut10 (
      .CLK(clk), .RES(res), .ASD(asd), .BSD(bsd), .SMP_STB(smp_stb),
      .VOL_WE(vol_we), .VOL_D(vol_d), .DROP_CLR(drop_clr),
      .MIX(mix10), .MIX_VLD(vld10), .BUSY(busy10), .DROP(drop10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int asd;
      int bsd;
      int vol;
      int e12;
      int e10s;
      int e10t;
   } vec_t;

   function automatic int ref_mix(int a, int b, int va, int vb, int w);
      int s, d, lim;
      s = (a - 64) * va + (b - 64) * vb;
      if (w == 12) return s;
`ifdef K007232_MIXER_SAT_EN
      lim = 1 << (w - 1);
      if (s > lim - 1) return lim - 1;
      if (s < -lim) return -lim;
      return s;
`else
      d = 1 << (12 - w);
      if (s >= 0) return s / d;
      return -((-s + d - 1) / d);
`endif
   endfunction

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wrvol(int v);
      vol_we = 1'b1;
      vol_d  = 8'(v);
      tick();
      vol_we = 1'b0;
      vol_a  = v & 15;
      vol_b  = (v >> 4) & 15;
   endtask

   task automatic run_pair(int a, int b, int wr_edge, int wr_val,
                           int e12, int e10);
      asd     = 7'(a);
      bsd     = 7'(b);
      smp_stb = 1'b1;
      tick();
      smp_stb = 1'b0;
      chk("busy_e0", int'(busy12), 1);
      for (int e = 1; e <= 5; e++) begin
         if (e == wr_edge) begin
            vol_we = 1'b1;
            vol_d  = 8'(wr_val);
         end
         tick();
         if (e == wr_edge) begin
            vol_we = 1'b0;
            vol_a  = wr_val & 15;
            vol_b  = (wr_val >> 4) & 15;
         end
         if (e < 5) begin
            chk("busy_mul", int'(busy12), 1);
            chk("vld_early", int'(vld12), 0);
         end else begin
            chk("vld_e5", int'(vld12), 1);
            chk("vld10_e5", int'(vld10), 1);
            chk("busy_e5", int'(busy12), 0);
            chk("mix12", int'(mix12), e12);
            chk("mix10", int'(mix10), e10);
         end
      end
      tick();
      chk("vld_after", int'(vld12), 0);
      chk("mix_hold", int'(mix12), e12);
   endtask

   task automatic strobe_run(int second, int clr_at, output int nvld);
      nvld    = 0;
      smp_stb = 1'b1;
      tick();
      smp_stb = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         smp_stb  = (i == second);
         drop_clr = (i == clr_at);
         tick();
         smp_stb  = 1'b0;
         drop_clr = 1'b0;
         nvld += int'(vld12);
      end
   endtask

   vec_t vecs[6];
   int   n, a, b, v, e10;

   initial begin
      vecs[0] = '{127,  64, 'h0F,   945,  511,  236};
      vecs[1] = '{  0,   0, 'hFF, -1920, -512, -480};
      vecs[2] = '{ 64,  64, 'hFF,     0,    0,    0};
      vecs[3] = '{127, 127, 'h00,     0,    0,    0};
      vecs[4] = '{100,  20, 'h37,   120,  120,   30};
      vecs[5] = '{  1, 126, 'hF1,   867,  511,  216};

      res = 1'b1; asd = '0; bsd = '0; smp_stb = 1'b0;
      vol_we = 1'b0; vol_d = '0; drop_clr = 1'b0;
      tick();
      tick();
      chk("rst_mix", int'(mix12), 0);
      chk("rst_vld", int'(vld12), 0);
      chk("rst_busy", int'(busy12), 0);
      chk("rst_busy10", int'(busy10), 0);
      chk("rst_drop", int'(drop12), 0);
      res = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         wrvol(vecs[i].vol);
`ifdef K007232_MIXER_SAT_EN
         e10 = vecs[i].e10s;
`else
         e10 = vecs[i].e10t;
`endif
         run_pair(vecs[i].asd, vecs[i].bsd, -1, 0, vecs[i].e12, e10);
      end

      // Second strobe 3 cycles in: dropped, single result.
      strobe_run(3, -1, n);
      chk("drop_vld_cnt", n, 1);
      chk("drop_set", int'(drop12), 1);
      chk("drop10_set", int'(drop10), 1);
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      chk("drop_clr", int'(drop12), 0);
      // Strobe on the SUM edge is also dropped.
      strobe_run(5, -1, n);
      chk("drop5_vld_cnt", n, 1);
      chk("drop5_set", int'(drop12), 1);
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      chk("drop_clr2", int'(drop12), 0);
      strobe_run(2, 2, n);
      chk("drop_win_cnt", n, 1);
      chk("drop_set_wins", int'(drop12), 1);
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;

      // Volume write mid-sample affects only the next one.
      wrvol('h0F);
      run_pair(127, 64, 2, 'h00, 945, ref_mix(127, 64, 15, 0, 10));
      run_pair(127, 64, -1, 0, 0, 0);

      // Reset mid-multiply abandons the sample.
      wrvol('h0F);
      run_pair(127, 64, -1, 0, 945, ref_mix(127, 64, 15, 0, 10));
      asd = 7'd127;
      smp_stb = 1'b1;
      tick();
      smp_stb = 1'b0;
      chk("busy_pre_rst", int'(busy12), 1);
      tick();
      tick();
      res = 1'b1;
      smp_stb = 1'b1;
      tick();
      res = 1'b0;
      smp_stb = 1'b0;
      vol_a = 0;
      vol_b = 0;
      chk("rst_mid_busy", int'(busy12), 0);
      chk("rst_mid_mix", int'(mix12), 0);
      chk("rst_mid_vld", int'(vld12), 0);
      wrvol('h0F);
      chk("rst_mid_busy2", int'(busy12), 0);
      run_pair(127, 64, -1, 0, 945, ref_mix(127, 64, 15, 0, 10));

      for (int i = 0; i < 20; i++) begin
         v = int'($urandom_range(0, 255));
         a = int'($urandom_range(0, 127));
         b = int'($urandom_range(0, 127));
         wrvol(v);
         run_pair(a, b, -1, 0, ref_mix(a, b, vol_a, vol_b, 12),
                  ref_mix(a, b, vol_a, vol_b, 10));
         if ($urandom_range(0, 1) == 1)
            tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
